// File: rtl/cdc_reg_bridge.sv
// cdc_reg_bridge: decodes W/R command frames from a CDC OUT byte stream into register-bus
// transfers and returns read data or ACK/NAK status on the IN byte stream.
module cdc_reg_bridge #(
  parameter int         TIMEOUT_CYCLES = 12000,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       configured_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [7:0] bus_addr_o,
  output logic [7:0] bus_wdata_o,
  output logic       bus_we_o,
  output logic       bus_re_o,
  input  logic [7:0] bus_rdata_i,
  input  logic       bus_ack_i,
  output logic       busy_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADDR  = 4'd1;
  localparam logic [3:0] S_LEN   = 4'd2;
  localparam logic [3:0] S_WDATA = 4'd3;
  localparam logic [3:0] S_WBUS  = 4'd4;
  localparam logic [3:0] S_RBUS  = 4'd5;
  localparam logic [3:0] S_RSEND = 4'd6;
  localparam logic [3:0] S_ACK   = 4'd7;
  localparam logic [3:0] S_NAK   = 4'd8;
  logic [3:0]    state, nxt;
  logic          is_wr, acc, in_frame, tmo_hit;
  logic [8:0]    cnt;
  logic [TW-1:0] tmo;
  logic [7:0]    addr;
  assign in_frame   = state == S_ADDR || state == S_LEN || state == S_WDATA;
  assign rx_ready_o = configured_i && (state == S_IDLE || in_frame);
  assign acc        = rx_valid_i && rx_ready_o;
  assign tmo_hit    = in_frame && !acc && tmo == TW'(TIMEOUT_CYCLES - 1);
  assign busy_o     = state != S_IDLE;
  assign bus_addr_o = addr;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (acc) nxt = (rx_data_i == 8'h57 || rx_data_i == 8'h52) ? S_ADDR : S_NAK;
      S_ADDR:  if (acc) nxt = S_LEN;
      S_LEN:   if (acc) nxt = is_wr ? S_WDATA : S_RBUS;
      S_WDATA: if (acc) nxt = S_WBUS;
      S_WBUS:  if (bus_ack_i) nxt = cnt == 9'd1 ? S_ACK : S_WDATA;
      S_RBUS:  if (bus_ack_i) nxt = S_RSEND;
      S_RSEND: if (tx_ready_i) nxt = cnt == 9'd0 ? S_IDLE : S_RBUS;
      S_ACK, S_NAK: if (tx_ready_i) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (tmo_hit) nxt = S_NAK;
    if (!configured_i) nxt = S_IDLE;
  end
  // strobes and tx_valid are flopped from the next state so they rise with state entry, glitch-free
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= S_IDLE;
      is_wr       <= 1'b0;
      cnt         <= '0;
      tmo         <= '0;
      addr        <= '0;
      bus_wdata_o <= '0;
      bus_we_o    <= 1'b0;
      bus_re_o    <= 1'b0;
      tx_data_o   <= '0;
      tx_valid_o  <= 1'b0;
    end else begin
      state      <= nxt;
      bus_we_o   <= nxt == S_WBUS;
      bus_re_o   <= nxt == S_RBUS;
      tx_valid_o <= nxt == S_RSEND || nxt == S_ACK || nxt == S_NAK;
      tmo        <= (configured_i && in_frame && !acc) ? tmo + 1'b1 : '0;
      if (!configured_i) begin
        addr <= '0;
        cnt  <= '0;
      end else begin
        if (state == S_IDLE && acc) is_wr <= rx_data_i == 8'h57;
        if (state == S_ADDR && acc) addr <= rx_data_i;
        if (state == S_LEN && acc) cnt <= rx_data_i == 8'h00 ? 9'd256 : {1'b0, rx_data_i};
        if (state == S_WDATA && acc) bus_wdata_o <= rx_data_i;
        if ((state == S_WBUS || state == S_RBUS) && bus_ack_i) begin
          addr <= addr + 8'd1;
          cnt  <= cnt - 9'd1;
        end
        if (state == S_RBUS && bus_ack_i) tx_data_o <= bus_rdata_i;
        if (nxt == S_ACK) tx_data_o <= ACK_BYTE;
        if (nxt == S_NAK) tx_data_o <= NAK_BYTE;
      end
    end
  end
endmodule

// File: tb/tb_cdc_reg_bridge.sv
// tb_cdc_reg_bridge: random-timing frames checked against a transaction-level model of the bridge.
module tb_cdc_reg_bridge;
  localparam int T = 12000;
  localparam logic [7:0] ACKB = 8'h06;
  localparam logic [7:0] NAKB = 8'h15;
  logic       clk = 0, rstn = 0, configured = 1, rx_valid = 0, tx_ready = 0, bus_ack = 0;
  logic [7:0] rx_data = 0, bus_rdata = 0;
  logic       rx_ready, tx_valid, bus_we, bus_re, busy;
  logic [7:0] tx_data, bus_addr, bus_wdata;
  typedef struct packed {logic w; logic [7:0] a; logic [7:0] d;} xfer_t;
  xfer_t      exp_bus[$], obs_bus[$];
  logic [7:0] exp_tx[$], obs_tx[$], fb[$];
  logic [7:0] mem[256], shadow[256];
  int         n_vec = 0, n_bad = 0, stall = -1;
  bit         ack_en = 1;
  logic       prev_hold = 0;
  logic [7:0] prev_data = 0;
  always #5 clk = ~clk;
  cdc_reg_bridge #(.TIMEOUT_CYCLES(T), .ACK_BYTE(ACKB), .NAK_BYTE(NAKB)) dut (
    .clk_i(clk), .rstn_i(rstn), .configured_i(configured),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_we_o(bus_we), .bus_re_o(bus_re),
    .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack), .busy_o(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rstn) begin
    if (bus_we && bus_ack) obs_bus.push_back({1'b1, bus_addr, bus_wdata});
    if (bus_re && bus_ack) obs_bus.push_back({1'b0, bus_addr, bus_rdata});
    if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
    if (bus_we || bus_re) check("we_re_excl", 32'(bus_we && bus_re), 0);
    if (prev_hold && tx_valid) check("tx_stable", tx_data, prev_data);
    prev_hold <= tx_valid && !tx_ready;
    prev_data <= tx_data;
  end
  // register-bus slave: random latency, plus stray acks while idle that must be ignored
  initial forever begin
    @(posedge clk); #1;
    if (ack_en && (bus_we || bus_re) && $urandom_range(0, 2) != 0) begin
      bus_ack = 1; bus_rdata = mem[bus_addr];
    end else begin
      bus_ack = ack_en && !(bus_we || bus_re) && $urandom_range(0, 3) == 0;
      bus_rdata = 8'($urandom);
    end
    @(negedge clk);
    if (bus_ack && bus_we) mem[bus_addr] = bus_wdata;
  end
  initial begin
    int st, tgt;
    st = 0; tgt = 0;
    forever begin
      @(posedge clk); #1;
      if (!tx_valid) begin
        tx_ready = 0; st = 0; tgt = stall < 0 ? int'($urandom_range(0, 2)) : stall;
      end else if (st < tgt) begin
        tx_ready = 0; st++;
      end else begin
        tx_ready = 1; st = 0; tgt = stall < 0 ? int'($urandom_range(0, 2)) : stall;
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1;
    @(negedge clk);
    while (!rx_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("rx_handshake", n, 0);
    @(posedge clk); #1;
    rx_valid = 0;
  endtask
  task automatic send_frame();
    foreach (fb[i]) begin
      send_byte(fb[i]);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin @(negedge clk); n++; end
    check("idle_reached", 32'(busy), 0);
    @(posedge clk); #1;
  endtask
  task automatic model_frame();
    int n;
    logic [7:0] a;
    if (fb[0] != 8'h57 && fb[0] != 8'h52) begin
      exp_tx.push_back(NAKB);
      return;
    end
    n = fb[2] == 8'h00 ? 256 : int'(fb[2]);
    for (int i = 0; i < n; i++) begin
      a = fb[1] + 8'(i);
      if (fb[0] == 8'h57) begin
        exp_bus.push_back({1'b1, a, fb[3+i]});
        shadow[a] = fb[3+i];
      end else begin
        exp_bus.push_back({1'b0, a, shadow[a]});
        exp_tx.push_back(shadow[a]);
      end
    end
    if (fb[0] == 8'h57) exp_tx.push_back(ACKB);
  endtask
  task automatic compare_all();
    check("bus_count", obs_bus.size(), exp_bus.size());
    while (obs_bus.size() > 0 && exp_bus.size() > 0) check("bus_xfer", 32'(obs_bus.pop_front()), 32'(exp_bus.pop_front()));
    check("tx_count", obs_tx.size(), exp_tx.size());
    while (obs_tx.size() > 0 && exp_tx.size() > 0) check("tx_byte", obs_tx.pop_front(), exp_tx.pop_front());
    obs_bus.delete(); exp_bus.delete(); obs_tx.delete(); exp_tx.delete();
  endtask
  task automatic run_frame();
    model_frame();
    send_frame();
    wait_idle();
    compare_all();
  endtask
  initial begin
    int n;
    logic [7:0] b, a, l;
    foreach (mem[i]) begin mem[i] = 8'($urandom); shadow[i] = mem[i]; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 1);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_we", 32'(bus_we), 0);
    check("rst_re", 32'(bus_re), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    @(posedge clk); #1;
    rstn = 1;
    fb = '{8'h57, 8'h10, 8'h02, 8'hAA, 8'hBB};
    run_frame();
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    shadow[8'hFE] = 8'h11; shadow[8'hFF] = 8'h22; shadow[8'h00] = 8'h33;
    stall = 5;
    fb = '{8'h52, 8'hFE, 8'h03};
    run_frame();
    stall = -1;
    fb = '{8'h41};
    run_frame();
    fb = '{8'h52, 8'h00, 8'h01};
    run_frame();
    fb = '{8'h57, 8'h30, 8'h01, 8'h5A};
    model_frame();
    send_byte(8'h57);
    repeat (T - 1) @(posedge clk);
    #1;
    check("tmo_edge_ready", 32'(rx_ready), 1);
    send_byte(8'h30); send_byte(8'h01); send_byte(8'h5A);
    wait_idle();
    compare_all();
    exp_tx.push_back(NAKB);
    send_byte(8'h57); send_byte(8'h20);
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < T + 10) begin @(negedge clk); n++; end
    check("tmo_cycles", n, T);
    wait_idle();
    compare_all();
    fb = '{8'h52, 8'h00, 8'h00};
    run_frame();
    ack_en = 0;
    fb = '{8'h57, 8'h40, 8'h01, 8'h99};
    send_frame();
    @(negedge clk);
    check("drop_we_pre", 32'(bus_we), 1);
    check("drop_addr", bus_addr, 8'h40);
    check("drop_wdata", bus_wdata, 8'h99);
    @(posedge clk); #1;
    configured = 0;
    @(negedge clk);
    check("drop_rx_ready", 32'(rx_ready), 0);
    @(negedge clk);
    check("drop_we_post", 32'(bus_we), 0);
    check("drop_busy", 32'(busy), 0);
    check("drop_tx_valid", 32'(tx_valid), 0);
    repeat (3) begin @(negedge clk); check("unconf_rx_ready", 32'(rx_ready), 0); end
    @(posedge clk); #1;
    configured = 1; ack_en = 1;
    fb = '{8'h57, 8'h05, 8'h01, 8'h77};
    run_frame();
    for (int k = 0; k < 10; k++) begin
      n = int'($urandom_range(0, 4));
      a = 8'($urandom);
      l = 8'($urandom_range(1, 6));
      if (n == 0) begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        fb = '{b};
      end else if (n < 3) begin
        fb = '{8'h57, a, l};
        for (int i = 0; i < int'(l); i++) fb.push_back(8'($urandom));
      end else fb = '{8'h52, a, l};
      run_frame();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
